// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams LSB-first bit pairs through one
// external full-adder cell and recirculates its carry in a flip-flop.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             load;
    logic             run;
    logic             last;
    logic [WIDTH-1:0] acc_next;

    assign load = (state_q == S_IDLE) && start;
    assign run  = (state_q == S_RUN);
    assign last = run && (cnt_q == LAST);

    // New sum bit enters at the MSB; for WIDTH=1 this is fa_sum alone.
    assign acc_next = WIDTH'({fa_sum, acc_q} >> 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        fa_a = run & shift_a_q[0];
        fa_b = run & shift_b_q[0];
        fa_c = run & carry_q;
    end

    assign sum  = sum_q;
    assign cout = cout_q;

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        unique case (1'b1)
            load: begin
                cnt_d     = '0;
                shift_a_d = a;
                shift_b_d = b;
                carry_d   = cin;
            end
            run: begin
                cnt_d     = cnt_q + 1'b1;
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                acc_d     = acc_next;
                carry_d   = fa_carry;
                if (last) begin
                    cnt_d  = '0;
                    sum_d  = acc_next;
                    cout_d = fa_carry;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl (WIDTH=8 and WIDTH=1)
// against an arithmetic reference model and a behavioural full adder.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       fa_a, fa_b, fa_c, fa_sum, fa_carry;

    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       cin1;
    logic       busy1, done1, cout1;
    logic       fa_a1, fa_b1, fa_c1, fa_sum1, fa_carry1;

    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] prev_sum;
    logic       prev_cout;

    always #5 clk = ~clk;

    assign fa_sum    = fa_a ^ fa_b ^ fa_c;
    assign fa_carry  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
    assign fa_sum1   = fa_a1 ^ fa_b1 ^ fa_c1;
    assign fa_carry1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
        .fa_sum(fa_sum), .fa_carry(fa_carry)
    );

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1),
        .fa_sum(fa_sum1), .fa_carry(fa_carry1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 add, entered and left in IDLE (cycle 0 / cycle 10).
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input bit keep, input bit scramble);
        logic [8:0] exp;
        int         m;
        int         cexp;
        exp = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
        a = ta; b = tb_; cin = tc; start = 1'b1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        step();
        if (!keep) start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m    = (1 << i) - 1;
            cexp = (((int'(ta) & m) + (int'(tb_) & m) + int'(tc)) >> i) & 1;
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_fa_a", fa_a, ta[i]);
            chk("run_fa_b", fa_b, tb_[i]);
            chk("run_fa_c", fa_c, cexp);
            chk("run_sum_hold", sum, prev_sum);
            chk("run_cout_hold", cout, prev_cout);
            if (scramble) begin
                a   = 8'($urandom);
                b   = 8'($urandom);
                cin = 1'($urandom);
            end
            step();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_sum", sum, exp[7:0]);
        chk("done_cout", cout, exp[8]);
        chk("done_fa_a", fa_a, 0);
        chk("done_fa_c", fa_c, 0);
        prev_sum  = exp[7:0];
        prev_cout = exp[8];
        step();
        chk("post_done", done, 0);
        chk("post_sum", sum, prev_sum);
    endtask

    task automatic run1(input logic ta, input logic tb_, input logic tc);
        logic [1:0] exp;
        exp = {1'b0, ta} + {1'b0, tb_} + {1'b0, tc};
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        chk("w1_run_done", done1, 0);
        chk("w1_fa_a", fa_a1, ta);
        chk("w1_fa_c", fa_c1, tc);
        step();
        chk("w1_done", done1, 1);
        chk("w1_done_busy", busy1, 0);
        chk("w1_sum", sum1, exp[0]);
        chk("w1_cout", cout1, exp[1]);
        step();
        chk("w1_post_done", done1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_fa", {fa_a, fa_b, fa_c}, 0);
        rst_n = 1'b1;

        run1(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++)
            run1(1'($urandom), 1'($urandom), 1'($urandom));

        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        run8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++)
            run8(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
        start = 1'b0;

        for (int k = 0; k < 25; k++)
            run8(8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));

        // Abort an add in cycle 4 of RUN.
        a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_fa", {fa_a, fa_b, fa_c}, 0);
        step();
        rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("after_abort_done", done, 0);
            chk("after_abort_busy", busy, 0);
            chk("after_abort_sum", sum, 0);
            step();
        end

        run8(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
